// File: rtl/pn_checker.sv
// Receive-side PN sequence checker: self-synchronises a local replica of the transmit
// recurrence, declares lock, then counts bit errors against the free-running replica.
module pn_checker #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAP_MASK   = 8'b0100_1110,
  parameter int              LOCK_COUNT  = 16,
  parameter int              WINDOW      = 256,
  parameter int              LOSS_THRESH = 32
) (
  input  logic        clk_o,
  input  logic        reset_n,
  input  logic        data_in,
  input  logic        data_valid,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        bit_err,
  output logic [15:0] err_count,
  output logic [23:0] bit_count
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(WIDTH);
  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0]   THRESH    = WIN_W'(LOSS_THRESH);

  localparam logic [1:0] ST_SEED   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [MATCH_W-1:0] r_match;
  logic [WIN_W-1:0]   r_win_bits;
  logic [WIN_W-1:0]   r_win_err;
  logic               r_bit_err;
  logic [15:0]        r_err_count;
  logic [23:0]        r_bit_count;

  logic               w_is_locked;
  logic               w_pred;
  logic               w_b;
  logic               w_err;
  logic [WIDTH-1:0]   w_hist_nxt;
  logic [FILL_W-1:0]  w_fill_inc;
  logic [WIN_W-1:0]   w_win_err_inc;
  logic               w_win_end;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [23:0] sat_inc24(input logic [23:0] v);
    return (&v) ? v : v + 24'd1;
  endfunction

  // Once locked the replica runs on its own prediction (flywheel), so a received
  // error never enters the history and cannot cause follow-on errors.
  assign w_is_locked   = (r_state == ST_LOCKED);
  assign w_pred        = ^(r_hist & TAP_MASK);
  assign w_b           = w_is_locked ? w_pred : data_in;
  assign w_err         = data_in ^ w_pred;
  assign w_hist_nxt    = {r_hist[WIDTH-2:0], w_b};
  assign w_fill_inc    = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
  assign w_win_err_inc = r_win_err + {{(WIN_W-1){1'b0}}, w_err};
  assign w_win_end     = (r_win_bits == WIN_LAST);

  always_ff @(posedge clk_o or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_SEED;
      r_hist     <= '0;
      r_fill     <= '0;
      r_match    <= '0;
      r_win_bits <= '0;
      r_win_err  <= '0;
      r_bit_err  <= 1'b0;
    end else begin
      r_bit_err <= 1'b0;
      if (data_valid) begin
        r_hist <= w_hist_nxt;
        case (r_state)
          ST_SEED: begin
            r_fill <= w_fill_inc;
            // An all-zero history is the lock-up state of the recurrence; keep seeding.
            if (w_fill_inc == FILL_FULL && w_hist_nxt != '0) begin
              r_state <= ST_VERIFY;
              r_match <= '0;
            end
          end
          ST_VERIFY: begin
            if (w_err) begin
              r_state <= ST_SEED;
              r_fill  <= '0;
            end else if (r_match == LOCK_LAST) begin
              r_state    <= ST_LOCKED;
              r_win_bits <= '0;
              r_win_err  <= '0;
            end else begin
              r_match <= r_match + 1'b1;
            end
          end
          ST_LOCKED: begin
            r_bit_err <= w_err;
            if (w_win_end) begin
              r_win_bits <= '0;
              r_win_err  <= '0;
              if (w_win_err_inc >= THRESH) begin
                r_state <= ST_SEED;
                r_fill  <= '0;
              end
            end else begin
              r_win_bits <= r_win_bits + 1'b1;
              r_win_err  <= w_win_err_inc;
            end
          end
          default: r_state <= ST_SEED;
        endcase
      end
    end
  end

  // Measurement counters: clear wins over a same-cycle increment.
  always_ff @(posedge clk_o or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count <= '0;
      r_bit_count <= '0;
    end else if (clr_cnt) begin
      r_err_count <= '0;
      r_bit_count <= '0;
    end else if (data_valid && w_is_locked) begin
      r_bit_count <= sat_inc24(r_bit_count);
      if (w_err) begin
        r_err_count <= sat_inc16(r_err_count);
      end
    end
  end

  assign locked    = w_is_locked;
  assign bit_err   = r_bit_err;
  assign err_count = r_err_count;
  assign bit_count = r_bit_count;

endmodule

// File: tb/tb_pn_checker.sv
// Directed bench for pn_checker: a transmit-side PN generator drives the checker and
// hand-derived lock latencies, counts and pulses are compared after each bit.
module tb_pn_checker;

  logic        clk_o = 1'b0;
  logic        reset_n;
  logic        data_in;
  logic        data_valid;
  logic        clr_cnt;
  logic        locked;
  logic        bit_err;
  logic [15:0] err_count;
  logic [23:0] bit_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  g;
  logic        mon_en = 1'b0;
  int          bad_pulses = 0;
  logic        seen_lock;

  always #5 clk_o = ~clk_o;

  pn_checker dut (
    .clk_o      (clk_o),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .clr_cnt    (clr_cnt),
    .locked     (locked),
    .bit_err    (bit_err),
    .err_count  (err_count),
    .bit_count  (bit_count)
  );

  always @(negedge clk_o) begin
    if (mon_en && bit_err) bad_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Presents one bit at a falling edge; returns on the next falling edge, after the
  // rising edge that consumed it, so outputs can be sampled directly.
  task automatic send_bit(input logic b, input int idle);
    data_in    = b;
    data_valid = 1'b1;
    @(negedge clk_o);
    data_valid = 1'b0;
    repeat (idle) @(negedge clk_o);
  endtask

  task automatic pn_bit(input logic flip, input int idle);
    logic b;
    b = ^(g & 8'h4E);
    g = {g[6:0], b};
    send_bit(b ^ flip, idle);
  endtask

  task automatic do_reset;
    reset_n    = 1'b0;
    data_valid = 1'b0;
    data_in    = 1'b0;
    clr_cnt    = 1'b0;
    repeat (2) @(negedge clk_o);
    reset_n = 1'b1;
    g       = 8'h01;
    @(negedge clk_o);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset_n = 1'b0; data_valid = 1'b0; data_in = 1'b0; clr_cnt = 1'b0;
    #12;
    check("rst_locked",  32'(locked),    32'd0);
    check("rst_bit_err", 32'(bit_err),   32'd0);
    check("rst_err_cnt", 32'(err_count), 32'd0);
    check("rst_bit_cnt", 32'(bit_count), 32'd0);

    // 1: clean stream, valid every cycle, lock after 8 fill + 16 matches
    do_reset;
    for (int i = 0; i < 23; i++) pn_bit(1'b0, 0);
    check("t1_locked_23", 32'(locked), 32'd0);
    pn_bit(1'b0, 0);
    check("t1_locked_24", 32'(locked),    32'd1);
    check("t1_err_cnt",   32'(err_count), 32'd0);
    check("t1_bit_cnt",   32'(bit_count), 32'd0);

    // 2: valid every 3rd cycle, 1000 bits, only post-lock bits counted
    do_reset;
    mon_en = 1'b1;
    for (int i = 0; i < 1000; i++) pn_bit(1'b0, 2);
    mon_en = 1'b0;
    check("t2_bit_cnt",    32'(bit_count), 32'd976);
    check("t2_err_cnt",    32'(err_count), 32'd0);
    check("t2_bad_pulses", 32'(bad_pulses), 32'd0);
    check("t2_locked",     32'(locked),    32'd1);

    // 3: single flipped bit while locked
    pn_bit(1'b1, 0);
    check("t3_bit_err_hi", 32'(bit_err),   32'd1);
    check("t3_err_cnt_1",  32'(err_count), 32'd1);
    @(negedge clk_o);
    check("t3_bit_err_idle", 32'(bit_err), 32'd0);
    pn_bit(1'b0, 0);
    check("t3_bit_err_lo", 32'(bit_err), 32'd0);
    for (int i = 0; i < 20; i++) pn_bit(1'b0, 0);
    check("t3_err_cnt_hold", 32'(err_count), 32'd1);
    check("t3_locked",       32'(locked),    32'd1);
    check("t3_bit_cnt",      32'(bit_count), 32'd998);

    // 4a: 32 errors in one window -> lock lost at the window end
    do_reset;
    for (int i = 0; i < 24; i++) pn_bit(1'b0, 0);
    for (int i = 0; i < 255; i++) pn_bit(logic'(i < 32), 0);
    check("t4_locked_255", 32'(locked), 32'd1);
    pn_bit(1'b0, 0);
    check("t4_locked_256", 32'(locked),    32'd0);
    check("t4_err_cnt_32", 32'(err_count), 32'd32);

    // 4b: 31 errors per window in two consecutive windows -> stays locked
    do_reset;
    for (int i = 0; i < 24; i++) pn_bit(1'b0, 0);
    for (int i = 0; i < 256; i++) pn_bit(logic'(i < 31), 0);
    check("t4_locked_w1",  32'(locked),    32'd1);
    check("t4_err_cnt_31", 32'(err_count), 32'd31);
    for (int i = 0; i < 256; i++) pn_bit(logic'(i < 31), 0);
    check("t4_locked_w2",  32'(locked),    32'd1);
    check("t4_err_cnt_62", 32'(err_count), 32'd62);
    check("t4_bit_cnt",    32'(bit_count), 32'd512);

    // 5: all-zero stream never leaves seeding; then PN starting from the seed's 1
    do_reset;
    seen_lock = 1'b0;
    for (int i = 0; i < 100; i++) begin
      send_bit(1'b0, 0);
      seen_lock = seen_lock | locked;
    end
    check("t5_zero_no_lock", 32'(seen_lock), 32'd0);
    send_bit(1'b1, 0);
    for (int i = 0; i < 15; i++) pn_bit(1'b0, 0);
    check("t5_locked_16", 32'(locked), 32'd0);
    pn_bit(1'b0, 0);
    check("t5_locked_17", 32'(locked), 32'd1);

    // 6: mismatch on verify match 10 restarts acquisition
    do_reset;
    for (int i = 0; i < 18; i++) pn_bit(1'b0, 0);
    pn_bit(1'b1, 0);
    for (int i = 0; i < 23; i++) pn_bit(1'b0, 0);
    check("t6_relock_23", 32'(locked), 32'd0);
    pn_bit(1'b0, 0);
    check("t6_relock_24", 32'(locked), 32'd1);

    clr_cnt = 1'b1;
    pn_bit(1'b1, 0);
    clr_cnt = 1'b0;
    check("t6_clr_err_cnt", 32'(err_count), 32'd0);
    check("t6_clr_bit_cnt", 32'(bit_count), 32'd0);
    check("t6_clr_bit_err", 32'(bit_err),   32'd1);
    pn_bit(1'b1, 0);
    check("t6_err_cnt_after", 32'(err_count), 32'd1);
    check("t6_bit_cnt_after", 32'(bit_count), 32'd1);

    // Asynchronous reset while bit_err is high and counters are non-zero
    #1 reset_n = 1'b0;
    #1;
    check("t6_arst_locked",  32'(locked),    32'd0);
    check("t6_arst_bit_err", 32'(bit_err),   32'd0);
    check("t6_arst_err_cnt", 32'(err_count), 32'd0);
    check("t6_arst_bit_cnt", 32'(bit_count), 32'd0);
    @(negedge clk_o);
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
